// File: rtl/text_pkg.sv
// Shared definitions for the text-mode pixel generator: glyph geometry,
// pipeline depth, text word layout and the 16-colour CGA palette.
package text_pkg;

  localparam int GLYPH_W  = 8;
  localparam int GLYPH_H  = 16;
  localparam int PIPE_LAT = 3;

  // Text word field positions
  localparam int CODE_LSB = 0;
  localparam int CODE_W   = 8;
  localparam int FG_LSB   = 8;
  localparam int BG_LSB   = 12;
  localparam int IDX_W    = 4;

  typedef struct packed {
    logic [IDX_W-1:0]  bg;
    logic [IDX_W-1:0]  fg;
    logic [CODE_W-1:0] code;
  } text_word_t;

  // 24-bit RGB for a 4-bit CGA palette index
  function automatic logic [23:0] palette(input logic [IDX_W-1:0] idx);
    logic [23:0] rgb;
    case (idx)
      4'd0:    rgb = 24'h000000;
      4'd1:    rgb = 24'h0000AA;
      4'd2:    rgb = 24'h00AA00;
      4'd3:    rgb = 24'h00AAAA;
      4'd4:    rgb = 24'hAA0000;
      4'd5:    rgb = 24'hAA00AA;
      4'd6:    rgb = 24'hAA5500;
      4'd7:    rgb = 24'hAAAAAA;
      4'd8:    rgb = 24'h555555;
      4'd9:    rgb = 24'h5555FF;
      4'd10:   rgb = 24'h55FF55;
      4'd11:   rgb = 24'h55FFFF;
      4'd12:   rgb = 24'hFF5555;
      4'd13:   rgb = 24'hFF55FF;
      4'd14:   rgb = 24'hFFFF55;
      default: rgb = 24'hFFFFFF;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/text_pixel_gen_if.sv
// Memory-side bus of the pixel generator: text buffer read port and
// font ROM read port. Both memories answer one cycle after the address.
interface text_pixel_gen_if #(
  parameter int TEXT_AW = 12
);
  logic [TEXT_AW-1:0] text_addr;
  logic [15:0]        text_data;
  logic [11:0]        font_addr;
  logic [7:0]         font_data;

  modport master (
    output text_addr,
    output font_addr,
    input  text_data,
    input  font_data
  );

  modport slave (
    input  text_addr,
    input  font_addr,
    output text_data,
    output font_data
  );
endinterface

// File: rtl/text_sync_delay.sv
// N-stage shift register that keeps de/hs/vs aligned with a pixel
// pipeline; shared by the overlay blocks of the debug display.
module text_sync_delay #(
  parameter int N = 3,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [N];

  // Shift the timing bits one stage per pixel clock
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[N-1];

endmodule

// File: rtl/text_pixel_gen.sv
// Text-mode pixel generator: tracks the pixel position from the timing
// stream, fetches the text word and glyph byte, and emits palette RGB
// three cycles after the timing input, with the syncs delayed to match.
module text_pixel_gen
  import text_pkg::*;
#(
  parameter int COLS    = 80,
  parameter int ROWS    = 30,
  parameter int TEXT_AW = 12
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             vid_de,
  input  logic             vid_hs,
  input  logic             vid_vs,
  text_pixel_gen_if.master mem,
  output logic             out_de,
  output logic             out_hs,
  output logic             out_vs,
  output logic [7:0]       out_r,
  output logic [7:0]       out_g,
  output logic [7:0]       out_b
);

  localparam int PX_LIMIT = COLS * GLYPH_W;
  localparam int LN_LIMIT = ROWS * GLYPH_H;
  localparam int PX_W     = $clog2(PX_LIMIT + 1);
  localparam int LN_W     = $clog2(LN_LIMIT + 1);
  localparam logic [PX_W-1:0]    PX_MAX = PX_W'(PX_LIMIT);
  localparam logic [LN_W-1:0]    LN_MAX = LN_W'(LN_LIMIT);
  localparam logic [TEXT_AW-1:0] COLS_A = TEXT_AW'(COLS);

  logic [PX_W-1:0]    px_cnt;
  logic [LN_W-1:0]    line_cnt;
  logic [TEXT_AW-1:0] line_base;
  logic [TEXT_AW-1:0] text_addr_q;
  logic [TEXT_AW-1:0] text_addr_cur;
  logic               in_frame;
  logic               de_q;
  logic               in_window;
  logic               visible_s0;

  logic [3:0]  glyph_row_s1;
  logic [2:0]  col_s1;
  logic        visible_s1;
  text_word_t  word_s1;

  logic [3:0]  fg_s2;
  logic [3:0]  bg_s2;
  logic [2:0]  col_s2;
  logic        visible_s2;
  logic        pix_bit;
  logic [23:0] rgb_s2;
  logic [23:0] rgb_q;
  logic [2:0]  sync_q;

  // Saturating limits keep the counters from wrapping back into valid text
  assign in_window  = (px_cnt < PX_MAX) && (line_cnt < LN_MAX);
  // A vsync cycle never shows a pixel, even when de rises with it
  assign visible_s0 = vid_de && in_window && in_frame && !vid_vs;

  // Column counter: follows de, cleared during blanking
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                px_cnt <= '0;
    else if (!vid_de)           px_cnt <= '0;
    else if (px_cnt != PX_MAX)  px_cnt <= px_cnt + PX_W'(1);
  end

  // Line counter and text row base; vsync wins over a coincident de edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      de_q      <= 1'b0;
      line_cnt  <= '0;
      line_base <= '0;
      in_frame  <= 1'b0;
    end else begin
      de_q <= vid_de;
      if (vid_vs) begin
        line_cnt  <= '0;
        line_base <= '0;
        in_frame  <= 1'b1;
      end else if (de_q && !vid_de && line_cnt != LN_MAX) begin
        line_cnt <= line_cnt + LN_W'(1);
        if (line_cnt[3:0] == 4'hF) line_base <= line_base + COLS_A;
      end
    end
  end

  // Text address tracks the pixel inside the window and holds outside it
  always_comb begin
    text_addr_cur = text_addr_q;
    if (vid_de && in_window) text_addr_cur = line_base + TEXT_AW'(px_cnt >> 3);
  end

  assign mem.text_addr = text_addr_cur;

  // Remember the last issued text address
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) text_addr_q <= '0;
    else         text_addr_q <= text_addr_cur;
  end

  // Stage 1: carry glyph row, pixel-in-cell and visibility alongside the text read
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      glyph_row_s1 <= '0;
      col_s1       <= '0;
      visible_s1   <= 1'b0;
    end else begin
      glyph_row_s1 <= line_cnt[3:0];
      col_s1       <= px_cnt[2:0];
      visible_s1   <= visible_s0;
    end
  end

  assign word_s1       = text_word_t'(mem.text_data);
  assign mem.font_addr = {word_s1.code, glyph_row_s1};

  // Stage 2: keep the colours and bit position while the font ROM answers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fg_s2      <= '0;
      bg_s2      <= '0;
      col_s2     <= '0;
      visible_s2 <= 1'b0;
    end else begin
      fg_s2      <= word_s1.fg;
      bg_s2      <= word_s1.bg;
      col_s2     <= col_s1;
      visible_s2 <= visible_s1;
    end
  end

  // Bit 7 of the glyph byte is the leftmost pixel of the cell
  always_comb begin
    rgb_s2  = '0;
    pix_bit = mem.font_data[3'd7 - col_s2];
    if (visible_s2) rgb_s2 = palette(pix_bit ? fg_s2 : bg_s2);
  end

  // Stage 3: output colour register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rgb_q <= '0;
    else         rgb_q <= rgb_s2;
  end

  assign out_r = rgb_q[23:16];
  assign out_g = rgb_q[15:8];
  assign out_b = rgb_q[7:0];

  text_sync_delay #(
    .N (PIPE_LAT),
    .W (3)
  ) u_sync_delay (
    .clk    (clk),
    .resetn (resetn),
    .d      ({vid_de, vid_hs, vid_vs}),
    .q      (sync_q)
  );

  assign {out_de, out_hs, out_vs} = sync_q;

endmodule

// File: tb/tb_text_pixel_gen.sv
// Directed bench for text_pixel_gen: behavioural text RAM and font ROM,
// pixel expectations from screen coordinates, plus hand-computed spot values.
module tb_text_pixel_gen;

  logic       clk;
  logic       resetn;
  logic       vid_de;
  logic       vid_hs;
  logic       vid_vs;
  logic       out_de;
  logic       out_hs;
  logic       out_vs;
  logic [7:0] out_r;
  logic [7:0] out_g;
  logic [7:0] out_b;

  text_pixel_gen_if #(.TEXT_AW(12)) tif ();

  text_pixel_gen #(
    .COLS    (80),
    .ROWS    (30),
    .TEXT_AW (12)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .vid_de (vid_de),
    .vid_hs (vid_hs),
    .vid_vs (vid_vs),
    .mem    (tif),
    .out_de (out_de),
    .out_hs (out_hs),
    .out_vs (out_vs),
    .out_r  (out_r),
    .out_g  (out_g),
    .out_b  (out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] text_mem [4096];
  logic [7:0]  font_rom [4096];

  // Synchronous text RAM and registered font ROM, one cycle of latency each
  always @(posedge clk) begin
    tif.text_data <= text_mem[tif.text_addr];
    tif.font_data <= font_rom[tif.font_addr];
  end

  typedef struct {
    logic        de;
    logic [2:0]  sync;
    logic [23:0] rgb;
    int          col;
  } exp_t;

  exp_t        hist [4];
  int          n_checks;
  int          n_errors;
  logic        framed;
  logic [23:0] obs_by_col  [1024];
  logic [11:0] addr_by_col [1024];
  logic [11:0] fa_by_col   [1024];

  function automatic logic [23:0] pal(input logic [3:0] idx);
    case (idx)
      4'd0:  return 24'h000000;  4'd1:  return 24'h0000AA;
      4'd2:  return 24'h00AA00;  4'd3:  return 24'h00AAAA;
      4'd4:  return 24'hAA0000;  4'd5:  return 24'hAA00AA;
      4'd6:  return 24'hAA5500;  4'd7:  return 24'hAAAAAA;
      4'd8:  return 24'h555555;  4'd9:  return 24'h5555FF;
      4'd10: return 24'h55FF55;  4'd11: return 24'h55FFFF;
      4'd12: return 24'hFF5555;  4'd13: return 24'hFF55FF;
      4'd14: return 24'hFFFF55;  default: return 24'hFFFFFF;
    endcase
  endfunction

  // 'A' from the VGA 8x16 font; other codes get a distinctive filler pattern
  function automatic logic [7:0] font_byte(input logic [7:0] code, input logic [3:0] row);
    if (code == 8'h41) begin
      case (row)
        4'd2: return 8'h10;
        4'd3: return 8'h38;
        4'd4: return 8'h6C;
        4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11: return 8'hC6;
        4'd7: return 8'hFE;
        default: return 8'h00;
      endcase
    end
    return code ^ {row, row};
  endfunction

  function automatic logic [15:0] text_word(input int a);
    if (a < 80)  return 16'h7F41;
    if (a < 160) return 16'h1E42;
    return {4'(a / 7), 4'(a / 3), 8'(a)};
  endfunction

  function automatic logic [23:0] exp_pixel(input int line, input int col);
    logic [15:0] w;
    logic [7:0]  fb;
    if (col >= 640 || line >= 480) return 24'h0;
    w  = text_word((line / 16) * 80 + col / 8);
    fb = font_byte(w[7:0], 4'(line % 16));
    return fb[3'(7 - (col % 8))] ? pal(w[11:8]) : pal(w[15:12]);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 4; i++) begin
      hist[i].de = 1'b0; hist[i].sync = 3'b000; hist[i].rgb = 24'h0; hist[i].col = 0;
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 1024; i++) begin
      obs_by_col[i] = 24'h123456; addr_by_col[i] = 12'hFFF; fa_by_col[i] = 12'hFFF;
    end
  endtask

  // One pixel cycle: drive inputs, then compare the outputs due from 3 cycles back
  task automatic applyStimulus(input logic de, input logic hs, input logic vs,
                               input int line, input int col);
    exp_t e;
    vid_de = de; vid_hs = hs; vid_vs = vs;
    e.de   = de & resetn;
    e.sync = resetn ? {de, hs, vs} : 3'b000;
    e.col  = col;
    e.rgb  = (resetn && de && !vs && framed) ? exp_pixel(line, col) : 24'h0;
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = e;
    @(negedge clk);
    if (de) addr_by_col[col] = tif.text_addr;
    if (hist[1].de) fa_by_col[hist[1].col] = tif.font_addr;
    if (hist[3].de) obs_by_col[hist[3].col] = {out_r, out_g, out_b};
    checkOutput("sync", 32'({out_de, out_hs, out_vs}), 32'(hist[3].sync));
    checkOutput("rgb", 32'({out_r, out_g, out_b}), 32'(hist[3].rgb));
    @(posedge clk); #1;
  endtask

  task automatic drive_line(input int npx, input int line, input logic vs_at_fall);
    for (int c = 0; c < npx; c++) applyStimulus(1'b1, 1'b0, 1'b0, line, c);
    applyStimulus(1'b0, 1'b0, vs_at_fall, line, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, line, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, line, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, line, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, line, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, line, 0);
    if (vs_at_fall) framed = 1'b1;
  endtask

  task automatic vs_pulse();
    applyStimulus(1'b0, 1'b0, 1'b1, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 0, 0);
    framed = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // Spot values for glyph rows that mix foreground and background
  task automatic check_row_spots(input int ln);
    if (ln == 5) begin
      checkOutput("l5_px0_fg", 32'(obs_by_col[0]), 32'h00FFFFFF);
      checkOutput("l5_px2_bg", 32'(obs_by_col[2]), 32'h00AAAAAA);
    end
    if (ln == 16) begin
      checkOutput("l16_taddr", 32'(addr_by_col[0]), 32'd80);
      checkOutput("l16_faddr", 32'(fa_by_col[0]), 32'h420);
      checkOutput("l16_px0_bg", 32'(obs_by_col[0]), 32'h000000AA);
      checkOutput("l16_px1_fg", 32'(obs_by_col[1]), 32'h00FFFF55);
    end
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: time %0t exceeded limit 900000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    framed   = 1'b0;
    resetn   = 1'b0;
    vid_de   = 1'b0;
    vid_hs   = 1'b0;
    vid_vs   = 1'b0;
    clear_hist();
    clear_logs();
    for (int a = 0; a < 4096; a++) text_mem[a] = text_word(a);
    for (int c = 0; c < 256; c++)
      for (int r = 0; r < 16; r++) font_rom[c * 16 + r] = font_byte(8'(c), 4'(r));

    $display("[TB] reset state");
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_rgb", 32'({out_r, out_g, out_b}), 32'h0);
    checkOutput("rst_sync", 32'({out_de, out_hs, out_vs}), 32'h0);
    checkOutput("rst_taddr", 32'(tif.text_addr), 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;

    $display("[TB] no vsync yet: blank pixels, delayed de");
    for (int ln = 0; ln < 3; ln++) begin
      clear_logs();
      drive_line(16, ln, 1'b0);
      checkOutput("novs_px3", 32'(obs_by_col[3]), 32'h0);
    end

    $display("[TB] frame 1: full-width line 0 then short lines");
    vs_pulse();
    clear_logs();
    drive_line(648, 0, 1'b0);
    checkOutput("l0_taddr0", 32'(addr_by_col[0]), 32'd0);
    checkOutput("l0_faddr0", 32'(fa_by_col[0]), 32'h410);
    checkOutput("l0_px0", 32'(obs_by_col[0]), 32'h00AAAAAA);
    checkOutput("l0_px639", 32'(obs_by_col[639]), 32'h00AAAAAA);
    checkOutput("l0_taddr640", 32'(addr_by_col[640]), 32'd79);
    checkOutput("l0_px640", 32'(obs_by_col[640]), 32'h0);
    checkOutput("l0_taddr647", 32'(addr_by_col[647]), 32'd79);
    for (int ln = 1; ln < 480; ln++) begin
      clear_logs();
      drive_line(10, ln, 1'b0);
      check_row_spots(ln);
    end

    $display("[TB] beyond the last text row");
    clear_logs();
    drive_line(10, 480, 1'b0);
    checkOutput("l480_taddr", 32'(addr_by_col[0]), 32'd2321);
    checkOutput("l480_px0", 32'(obs_by_col[0]), 32'h0);
    drive_line(10, 481, 1'b0);
    drive_line(10, 482, 1'b0);

    $display("[TB] vsync on the de falling edge");
    drive_line(10, 483, 1'b1);
    clear_logs();
    drive_line(10, 0, 1'b0);
    checkOutput("vsfall_taddr", 32'(addr_by_col[0]), 32'd0);
    checkOutput("vsfall_faddr", 32'(fa_by_col[0]), 32'h410);
    checkOutput("vsfall_px0", 32'(obs_by_col[0]), 32'h00AAAAAA);
    drive_line(10, 1, 1'b0);

    $display("[TB] vsync with de rising");
    clear_logs();
    applyStimulus(1'b1, 1'b0, 1'b1, 0, 0);
    framed = 1'b1;
    for (int c = 1; c < 16; c++) applyStimulus(1'b1, 1'b0, 1'b0, 0, c);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
    checkOutput("vsde_px0_blank", 32'(obs_by_col[0]), 32'h0);
    checkOutput("vsde_taddr1", 32'(addr_by_col[1]), 32'd0);
    checkOutput("vsde_row", 32'(fa_by_col[1][3:0]), 32'h0);
    checkOutput("vsde_px1", 32'(obs_by_col[1]), 32'h00AAAAAA);
    drive_line(10, 1, 1'b0);

    $display("[TB] reset mid-line");
    for (int c = 0; c < 6; c++) applyStimulus(1'b1, 1'b0, 1'b0, 2, c);
    resetn = 1'b0;
    #1;
    checkOutput("async_rgb", 32'({out_r, out_g, out_b}), 32'h0);
    checkOutput("async_de", 32'(out_de), 32'h0);
    framed = 1'b0;
    clear_hist();
    applyStimulus(1'b1, 1'b0, 1'b0, 2, 6);
    applyStimulus(1'b1, 1'b0, 1'b0, 2, 7);
    resetn = 1'b1;
    for (int c = 8; c < 14; c++) applyStimulus(1'b1, 1'b0, 1'b0, 2, c);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2, 0);
    clear_logs();
    drive_line(10, 3, 1'b0);
    checkOutput("postrst_px0", 32'(obs_by_col[0]), 32'h0);

    $display("[TB] frame 2 after reset");
    vs_pulse();
    for (int ln = 0; ln < 18; ln++) begin
      clear_logs();
      drive_line(10, ln, 1'b0);
      if (ln == 0) checkOutput("f2_l0_px0", 32'(obs_by_col[0]), 32'h00AAAAAA);
      check_row_spots(ln);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/text_pixel_gen.md
Name: text_pixel_gen

Overview:
- Reader side of the 4kx8 character font ROM: turns the video timing stream into text-mode pixels.
- Fetches a character/attribute word from the text buffer and addresses the font ROM with {code, glyph row}.
- Picks the glyph bit for the current pixel and drives palette-mapped RGB with timing delayed to match.
- Sits between the video timing generator and the HDMI/LCD output stage of the debug display.

Parameters:
- COLS, 80, text columns per line (8 px each).
- ROWS, 30, text rows per frame (16 px each).
- TEXT_AW, 12, text buffer address width; COLS*ROWS must be at most 2**TEXT_AW.

Ports:
- clk  in  1  pixel clock; one pixel per cycle.
- resetn  in  1  asynchronous active-low reset.
- vid_de  in  1  display enable from the timing generator.
- vid_hs  in  1  hsync, passed through.
- vid_vs  in  1  vsync, active high; starts a frame.
- text_addr  out  TEXT_AW  text buffer read address (synchronous RAM, 1-cycle latency).
- text_data  in  16  [7:0] char code, [11:8] fg palette index, [15:12] bg palette index.
- font_addr  out  12  font ROM address {code[7:0], glyph_row[3:0]}.
- font_data  in  8  font ROM byte (registered ROM, 1-cycle latency); bit 7 is the leftmost pixel.
- out_de, out_hs, out_vs  out  1 each  timing delayed by 3 cycles.
- out_r, out_g, out_b  out  8 each  pixel colour.

Behaviour:
- Reset: all outputs 0; px_cnt, line_cnt, line_base and in_frame are 0; pipeline registers are 0.
- Counters:
  - px_cnt is the column of the current pixel; it increments on each vid_de=1 cycle and clears when vid_de=0.
  - line_cnt increments on the vid_de falling edge.
  - glyph_row = line_cnt[3:0]. line_base increases by COLS when glyph_row wraps 15→0.
- vid_vs=1: clears line_cnt and line_base, and sets in_frame. vs takes priority over a simultaneous de edge.
- Active-text window: px_cnt < COLS*8 and line_cnt < ROWS*16. Outside it, the pixel is blank.
- text_addr:
  - Equals line_base + px_cnt[..3], combinational from registers, in the cycle the pixel is presented on vid_de.
  - Holds its last value outside the window.
- Pipeline (stage 0 is the input cycle):
  - S0: text_addr driven.
  - S1: text_data valid; font_addr = {text_data[7:0], glyph_row delayed 1} is combinational. fg/bg, px_cnt[2:0] and the blank flag are registered.
  - S2: font_data valid; bit = font_data[7 - col_bit] is selected.
  - S3: output register.
- Output pixel:
  - bit=1 → palette[fg]; bit=0 → palette[bg].
  - Blank, vid_de low, or in_frame=0 → all of r/g/b = 0.
- Latency: exactly 3 cycles from vid_de/hs/vs input to out_de/hs/vs and the matching RGB, with no bubbles.
- Bandwidth: one text read and one font read per pixel; no caching needed.
- Reset mid-frame:
  - Pipeline flushes to 0 and in_frame clears.
  - RGB stays 0 until the next vid_vs; delayed syncs still propagate after reset release.
- Overflow: line_cnt saturates at ROWS*16; px_cnt saturates at COLS*8. No wrap into valid text.

Decomposition:
- Package text_pkg holds:
  - the 16-entry palette constant (24-bit RGB, CGA-style: 0=black, 7=light grey, 15=white);
  - text word field positions;
  - GLYPH_W=8, GLYPH_H=16, PIPE_LAT=3.
- Sub-module text_sync_delay: parameterised N-stage shift register for de/hs/vs, reused for other overlay blocks.

Test Plan:
- Reset release, no vs, vid_de toggling → out_r/g/b stay 0; out_de is vid_de delayed by exactly 3 cycles.
- vs pulse, then first line with text_data=0x7F41 ('A', fg 15, bg 7), font_data model from the reference font → first 8 pixels match glyph row 0 of 0x41 (white on light grey), pixel at input cycle n appears at output cycle n+3.
- Line 16 start after a vs pulse → text_addr=COLS (80) at px 0; font_addr low nibble = 0.
- Pixel 640 or line 480 with COLS=80, ROWS=30 → rgb=0; text_addr does not exceed 2399.
- vid_vs and vid_de rising in the same cycle → counters cleared, pixel blank, next line renders row 0.
- resetn pulled low mid-line for 2 cycles → outputs 0 asynchronously; after release, rgb=0 until the next vs, then a correct frame.
